// File: rtl/aud_rec_writer.sv
// rtl/aud_rec_writer.sv - WM8731 ADC I2S capture, writes 16-bit samples sequentially to SRAM
// Optional macro AUD_REC_STEREO_AVG_EN: capture both channels and store (L+R)>>>1 per frame.
module aud_rec_writer #(
    parameter int          DATA_W    = 16,
    parameter int          ADDR_W    = 20,
    parameter int unsigned MAX_WORDS = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_aud_bclk,
    input  logic              i_aud_adclrck,
    input  logic              i_aud_adcdat,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic              o_busy,
    output logic              o_full
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_LRC,
        S_SKIP,
        S_SHIFT,
        S_WRITE,
        S_PAUSE,
        S_WAIT_R,
        S_SKIP_R,
        S_SHIFT_R
    } state_t;

    state_t             state;
    logic [1:0]         bclk_sync, lrck_sync, dat_sync;
    logic               bclk_d, lrck_d;
    logic [DATA_W-1:0]  sh;
    logic [CNT_W-1:0]   bitcnt;
    logic [ADDR_W-1:0]  addr;

    logic               bclk_rise, lrck_fall, lrck_rise, last_bit;
    logic [DATA_W-1:0]  sh_next;
    logic [ADDR_W-1:0]  addr_inc;

    // Codec pins are asynchronous: two flops, then one more stage for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_d    <= 1'b0;
            lrck_d    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], i_aud_bclk};
            lrck_sync <= {lrck_sync[0], i_aud_adclrck};
            dat_sync  <= {dat_sync[0], i_aud_adcdat};
            bclk_d    <= bclk_sync[1];
            lrck_d    <= lrck_sync[1];
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_d;
    assign lrck_fall = ~lrck_sync[1] & lrck_d;
    assign lrck_rise = lrck_sync[1] & ~lrck_d;
    assign sh_next   = {sh[DATA_W-2:0], dat_sync[1]};
    assign last_bit  = (bitcnt == CNT_W'(DATA_W - 1));
    assign addr_inc  = addr + ADDR_W'(1);

`ifdef AUD_REC_STEREO_AVG_EN
    logic [DATA_W-1:0] sh_l;
    logic [DATA_W:0]   avg_sum;
    // 17-bit signed sum; taking the upper 16 bits is the arithmetic shift plus truncation.
    assign avg_sum = {sh_l[DATA_W-1], sh_l} + {sh_next[DATA_W-1], sh_next};
`endif

    assign o_sram_addr = addr;
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            sh          <= '0;
            bitcnt      <= '0;
            addr        <= '0;
            o_end_addr  <= '0;
            o_sram_data <= '0;
            o_sram_we   <= 1'b0;
            o_full      <= 1'b0;
`ifdef AUD_REC_STEREO_AVG_EN
            sh_l        <= '0;
`endif
        end else begin
            o_sram_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start && !i_stop && !i_pause) begin
                        addr       <= '0;
                        o_end_addr <= '0;
                        o_full     <= 1'b0;
                        state      <= S_WAIT_LRC;
                    end
                end
                // A write in flight always completes before stop/pause take effect.
                S_WRITE: begin
                    addr       <= addr_inc;
                    o_end_addr <= addr_inc;
                    if (addr_inc == ADDR_W'(MAX_WORDS)) begin
                        o_full <= 1'b1;
                        state  <= S_IDLE;
                    end else if (i_stop) begin
                        state <= S_IDLE;
                    end else if (i_pause) begin
                        state <= S_PAUSE;
                    end else begin
                        state <= S_WAIT_LRC;
                    end
                end
                S_PAUSE: begin
                    if (i_stop)
                        state <= S_IDLE;
                    else if (i_start && !i_pause)
                        state <= S_WAIT_LRC;
                end
                default: begin
                    if (i_stop) begin
                        state <= S_IDLE;
                    end else if (i_pause) begin
                        state <= S_PAUSE;
                    end else begin
                        case (state)
                            S_WAIT_LRC: if (lrck_fall) state <= S_SKIP;
                            S_SKIP: begin
                                if (bclk_rise) begin
                                    bitcnt <= '0;
                                    state  <= S_SHIFT;
                                end
                            end
                            S_SHIFT: begin
                                if (lrck_rise) begin
                                    state <= S_WAIT_LRC;
                                end else if (bclk_rise) begin
                                    sh     <= sh_next;
                                    bitcnt <= bitcnt + CNT_W'(1);
                                    if (last_bit) begin
`ifdef AUD_REC_STEREO_AVG_EN
                                        sh_l  <= sh_next;
                                        state <= S_WAIT_R;
`else
                                        o_sram_data <= sh_next;
                                        o_sram_we   <= 1'b1;
                                        state       <= S_WRITE;
`endif
                                    end
                                end
                            end
`ifdef AUD_REC_STEREO_AVG_EN
                            S_WAIT_R: if (lrck_rise) state <= S_SKIP_R;
                            S_SKIP_R: begin
                                if (bclk_rise) begin
                                    bitcnt <= '0;
                                    state  <= S_SHIFT_R;
                                end
                            end
                            // A falling lrck here already marks the next frame, so resync at SKIP.
                            S_SHIFT_R: begin
                                if (lrck_fall) begin
                                    state <= S_SKIP;
                                end else if (bclk_rise) begin
                                    sh     <= sh_next;
                                    bitcnt <= bitcnt + CNT_W'(1);
                                    if (last_bit) begin
                                        o_sram_data <= avg_sum[DATA_W:1];
                                        o_sram_we   <= 1'b1;
                                        state       <= S_WRITE;
                                    end
                                end
                            end
`endif
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aud_rec_writer.sv
// tb/tb_aud_rec_writer.sv - directed bench for aud_rec_writer (MAX_WORDS=4 instance)
module tb_aud_rec_writer;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0, i_pause = 1'b0, i_stop = 1'b0;
    logic        i_aud_bclk = 1'b0, i_aud_adclrck = 1'b1, i_aud_adcdat = 1'b0;
    logic [19:0] o_sram_addr, o_end_addr;
    logic [15:0] o_sram_data;
    logic        o_sram_we, o_busy, o_full;

    int passed = 0;
    int total  = 0;

    logic [19:0] wq_addr[$];
    logic [15:0] wq_data[$];

    aud_rec_writer #(.DATA_W(16), .ADDR_W(20), .MAX_WORDS(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
        .i_aud_bclk(i_aud_bclk), .i_aud_adclrck(i_aud_adclrck), .i_aud_adcdat(i_aud_adcdat),
        .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .o_sram_we(o_sram_we),
        .o_end_addr(o_end_addr), .o_busy(o_busy), .o_full(o_full)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_sram_we === 1'b1) begin
            wq_addr.push_back(o_sram_addr);
            wq_data.push_back(o_sram_data);
        end
    end

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (4) @(posedge i_clk);
        #1 i_rst = 1'b0;
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic pulse_start();
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
    endtask

    task automatic pulse_pause();
        @(posedge i_clk); #1 i_pause = 1'b1;
        @(posedge i_clk); #1 i_pause = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge i_clk); #1 i_stop = 1'b1;
        @(posedge i_clk); #1 i_stop = 1'b0;
    endtask

    // 20 bclk slots per channel, bclk = i_clk/8; slot 0 is the I2S delay bit, slots 1..16 MSB..LSB.
    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        logic [15:0] w;
        for (int ch = 0; ch < 2; ch++) begin
            w = (ch == 0) ? l : r;
            for (int s = 0; s < 20; s++) begin
                @(posedge i_clk); #1;
                i_aud_bclk    = 1'b0;
                i_aud_adclrck = (ch == 1);
                i_aud_adcdat  = (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
                repeat (4) @(posedge i_clk);
                #1 i_aud_bclk = 1'b1;
                repeat (3) @(posedge i_clk);
            end
        end
    endtask

    task automatic check_write(input int idx, input logic [19:0] ea, input logic [15:0] ed, input string name);
        logic [19:0] ga;
        logic [15:0] gd;
        ga = (idx < wq_addr.size()) ? wq_addr[idx] : 'x;
        gd = (idx < wq_data.size()) ? wq_data[idx] : 'x;
        total++;
        if (ga !== ea) $display("FAIL %s addr[%0d]: got %h want %h", name, idx, ga, ea);
        else if (gd !== ed) $display("FAIL %s data[%0d]: got %h want %h", name, idx, gd, ed);
        else passed++;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({o_sram_addr, o_sram_data, o_sram_we, o_end_addr, o_busy, o_full} !== '0)
            $display("FAIL reset outputs: addr=%h data=%h we=%b end=%h busy=%b full=%b want all 0",
                     o_sram_addr, o_sram_data, o_sram_we, o_end_addr, o_busy, o_full);
        else passed++;
    endtask

    task automatic test_basic();
        logic [15:0] exp_d[3] = '{16'h1234, 16'h8001, 16'h0000};
        do_reset();
        pulse_start();
        for (int i = 0; i < 3; i++) send_frame(exp_d[i], exp_d[i]);
        repeat (10) @(posedge i_clk); #1;
        total++;
        if (wq_addr.size() != 3) $display("FAIL basic count: got %0d want 3", wq_addr.size());
        else passed++;
        for (int i = 0; i < 3; i++) check_write(i, 20'(i), exp_d[i], "basic");
        total++;
        if (o_end_addr !== 20'd3 || o_busy !== 1'b1 || o_full !== 1'b0)
            $display("FAIL basic status: end=%h busy=%b full=%b want 3/1/0", o_end_addr, o_busy, o_full);
        else passed++;
    endtask

    task automatic test_pause();
        do_reset();
        pulse_start();
        send_frame(16'h1111, 16'h1111);
        pulse_pause();
        send_frame(16'h2222, 16'h2222);
        send_frame(16'h3333, 16'h3333);
        total++;
        if (wq_addr.size() != 1) $display("FAIL pause writes while paused: got %0d want 1", wq_addr.size());
        else passed++;
        pulse_start();
        send_frame(16'hBEEF, 16'hBEEF);
        repeat (10) @(posedge i_clk); #1;
        check_write(0, 20'd0, 16'h1111, "pause");
        check_write(1, 20'd1, 16'hBEEF, "pause");
        total++;
        if (o_end_addr !== 20'd2) $display("FAIL pause end_addr: got %h want 2", o_end_addr);
        else passed++;
    endtask

    task automatic test_stop();
        do_reset();
        pulse_start();
        send_frame(16'h4444, 16'h4444);
        fork
            send_frame(16'h5555, 16'h5555);
            begin
                repeat (80) @(posedge i_clk);
                pulse_stop();
            end
        join
        repeat (10) @(posedge i_clk); #1;
        total++;
        if (wq_addr.size() != 1) $display("FAIL stop count: got %0d want 1", wq_addr.size());
        else passed++;
        total++;
        if (o_busy !== 1'b0 || o_end_addr !== 20'd1)
            $display("FAIL stop status: busy=%b end=%h want 0/1", o_busy, o_end_addr);
        else passed++;
    endtask

    task automatic test_full();
        do_reset();
        pulse_start();
        for (int i = 0; i < 6; i++) send_frame(16'h1000 + 16'(i), 16'h1000 + 16'(i));
        repeat (10) @(posedge i_clk); #1;
        total++;
        if (wq_addr.size() != 4) $display("FAIL full count: got %0d want 4", wq_addr.size());
        else passed++;
        for (int i = 0; i < 4; i++) check_write(i, 20'(i), 16'h1000 + 16'(i), "full");
        total++;
        if (o_full !== 1'b1 || o_busy !== 1'b0 || o_end_addr !== 20'd4)
            $display("FAIL full status: full=%b busy=%b end=%h want 1/0/4", o_full, o_busy, o_end_addr);
        else passed++;
        pulse_start();
        total++;
        if (o_full !== 1'b0) $display("FAIL full clear: got %b want 0", o_full);
        else passed++;
        send_frame(16'hABCD, 16'hABCD);
        repeat (10) @(posedge i_clk); #1;
        check_write(4, 20'd0, 16'hABCD, "full_restart");
    endtask

    task automatic test_midframe();
        do_reset();
        fork
            send_frame(16'hAAAA, 16'hAAAA);
            begin
                repeat (42) @(posedge i_clk);
                pulse_start();
            end
        join
        send_frame(16'h1357, 16'h1357);
        repeat (10) @(posedge i_clk); #1;
        total++;
        if (wq_addr.size() != 1) $display("FAIL midframe count: got %0d want 1", wq_addr.size());
        else passed++;
        check_write(0, 20'd0, 16'h1357, "midframe");
    endtask

    task automatic test_stereo();
`ifdef AUD_REC_STEREO_AVG_EN
        logic [15:0] e0 = 16'h4000;
`else
        logic [15:0] e0 = 16'h7FFF;
`endif
        do_reset();
        pulse_start();
        send_frame(16'h7FFF, 16'h0001);
        send_frame(16'h8000, 16'h8000);
        repeat (10) @(posedge i_clk); #1;
        check_write(0, 20'd0, e0, "stereo");
        check_write(1, 20'd1, 16'h8000, "stereo");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_stop();
        test_full();
        test_midframe();
        test_stereo();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/aud_rec_writer.md
Name: aud_rec_writer

Overview:
- Capture side of the audio path: deserialises the WM8731 ADC I2S stream into 16-bit samples and writes them to SRAM sequentially.
- Produces `o_end_addr`, which feeds the playback DSP's end-address input.
- Runs on the system clock. BCLK, ADCLRCK and ADCDAT are treated as slow asynchronous inputs and are synchronised and edge-detected internally.

Parameters:
- DATA_W, 16, sample width and SRAM word width
- ADDR_W, 20, SRAM address width
- MAX_WORDS, 20'hFFFFF, number of words writable before the full condition

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse; begin a new recording, or resume from pause
- i_pause  in  1  one-cycle pulse; suspend capture and keep the address
- i_stop  in  1  one-cycle pulse; end the recording
- i_aud_bclk  in  1  codec bit clock (async)
- i_aud_adclrck  in  1  codec ADC LR clock (async); low = left channel
- i_aud_adcdat  in  1  codec serial ADC data (async)
- o_sram_addr  out  ADDR_W  write address
- o_sram_data  out  DATA_W  write data
- o_sram_we  out  1  write strobe, one-cycle pulse
- o_end_addr  out  ADDR_W  words written in the current/last recording
- o_busy  out  1  high in every state except IDLE
- o_full  out  1  sticky; MAX_WORDS reached

Behaviour:
- Reset: all outputs 0, state IDLE, shift register and bit counter cleared. A reset mid-sample discards the partial sample with no write.
- Input conditioning: 2-FF synchroniser on bclk, lrck and dat. A bclk rising edge is detected when the synchronised bclk was 0 last cycle and is 1 now. A lrck falling edge is detected the same way.
- Control priority, same cycle: stop > pause > start.
- IDLE:
  - On start: addr←0, end_addr←0, full←0, go to WAIT_LRC.
- WAIT_LRC:
  - Wait for a synchronised lrck falling edge, then go to SKIP.
  - This guarantees capture always begins at a frame boundary.
- SKIP:
  - Ignore the first bclk rising edge (I2S one-bit delay), then go to SHIFT with bitcnt←0.
- SHIFT:
  - On each bclk rising edge: shift `sh` left and insert dat at the LSB, bitcnt++. The first bit is the MSB.
  - After the 16th bit, go to WRITE.
  - If lrck rises before 16 bits have arrived, discard the sample and go to WAIT_LRC.
- WRITE (exactly one cycle):
  - o_sram_we=1, o_sram_data=sh, o_sram_addr = current addr.
  - Next cycle: addr++, end_addr←addr+1.
  - If addr+1 == MAX_WORDS: full←1 and go to IDLE. Otherwise go to WAIT_LRC.
- Address timing: o_sram_addr is stable while we is high and changes only on the cycle after the we pulse.
- Latency: the we pulse occurs 1 cycle after the detected bclk edge that carries the LSB. Including the synchroniser, that is 3 i_clk cycles after the raw bclk rising edge.
- PAUSE:
  - Entered from WAIT_LRC, SKIP or SHIFT on i_pause; a partial sample is discarded.
  - An i_pause arriving during WRITE takes effect after the write completes.
  - addr and end_addr are held.
  - On start: go to WAIT_LRC with no address reset.
- Stop, from any non-IDLE state:
  - A partial sample is discarded and the state goes to IDLE.
  - A stop during WRITE still completes the write and increment first.
  - end_addr holds its final value until the next start.
- Start while in WAIT_LRC, SKIP, SHIFT or WRITE: ignored.
- While full: starts are accepted only from IDLE, and such a start clears full.
- Playback requirement: minimum i_clk = 4× bclk frequency.

Optional Feature:
- Macro: AUD_REC_STEREO_AVG_EN.
- Defined:
  - The right channel (lrck high) is also captured with identical timing, into a second register.
  - After the right LSB, WRITE stores (L+R)>>>1 using a 17-bit signed sum, arithmetic shift, truncated to 16 bits.
  - One word per frame.
  - A pause/stop before the right channel completes discards the left sample.
- Undefined: left channel only; right-channel bits are ignored.

Test Plan:
- Reset, start, then 3 frames with left=16'h1234, 16'h8001, 16'h0000 (bclk = i_clk/8) -> three we pulses at addr 0,1,2 with data 1234/8001/0000; end_addr=3; o_busy=1.
- Pause after frame 1, send 2 frames, start, send frame with left=16'hBEEF -> no writes while paused; the next write is at addr 1 with data BEEF; end_addr=2.
- Stop asserted after 9 bits of the second sample -> no write for that sample; state IDLE; end_addr=1; o_busy=0.
- MAX_WORDS=4, send 6 frames -> exactly 4 writes (addr 0-3), o_full=1 and IDLE after the 4th; a new start clears full and the next write is at addr 0.
- Start asserted mid-frame (lrck low, bit 5) -> that frame is skipped; the first write carries the next full frame's left sample.
- AUD_REC_STEREO_AVG_EN with L=16'h7FFF, R=16'h0001 -> data 16'h4000; with L=16'h8000, R=16'h8000 -> data 16'h8000.
